// File: rtl/mmcm_drp_ctrl.sv
// MMCM run-time reconfiguration sequencer.
// Applies a stream of read-modify-write ops to the MMCM over its DRP port.
// The MMCM is held in reset while the ops are applied. After the last op the
// reset is released, and lock is qualified by a stability filter and a timeout.
// Everything runs on the buffered 200 MHz system clock, which does not depend
// on any MMCM output.
//
// Op handshake: an op transfers on a rising edge where op_valid and op_ready
// are both high. op_ready never depends on op_valid. op_ready is high only in
// IDLE and GET_OP. The op fields must be stable while op_valid is high.
module mmcm_drp_ctrl #(
  parameter int DRP_ADDR_W   = 7,
  parameter int DRP_DATA_W   = 16,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_FILTER  = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                  sysclk_200mhz,
  input  logic                  rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [DRP_ADDR_W-1:0] op_addr,
  input  logic [DRP_DATA_W-1:0] op_mask,
  input  logic [DRP_DATA_W-1:0] op_data,
  input  logic                  op_last,
  output logic                  drp_den,
  output logic                  drp_dwe,
  output logic [DRP_ADDR_W-1:0] drp_daddr,
  output logic [DRP_DATA_W-1:0] drp_di,
  input  logic [DRP_DATA_W-1:0] drp_do,
  input  logic                  drp_drdy,
  output logic                  mmcm_rst,
  input  logic                  mmcm_locked,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic                  clk_ok,
  output logic [3:0]            dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RD_REQ    = 4'd1,
    S_RD_WAIT   = 4'd2,
    S_WR_REQ    = 4'd3,
    S_WR_WAIT   = 4'd4,
    S_GET_OP    = 4'd5,
    S_RELEASE   = 4'd6,
    S_WAIT_LOCK = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  localparam int TMR_W = $clog2(DRDY_TIMEOUT + 1);
  localparam int FLT_W = $clog2(LOCK_FILTER + 1);
  localparam int LTM_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(DRDY_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [FLT_W-1:0] FLT_LIMIT = FLT_W'(LOCK_FILTER);
  localparam logic [FLT_W-1:0] FLT_ONE   = FLT_W'(1);
  localparam logic [LTM_W-1:0] LTM_LIMIT = LTM_W'(LOCK_TIMEOUT);
  localparam logic [LTM_W-1:0] LTM_ONE   = LTM_W'(1);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_DRDY = 2'd1;
  localparam logic [1:0] ERR_LOCK = 2'd2;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_run;
  logic                  r_lock_s1;
  logic                  r_lock_s2;
  logic [DRP_DATA_W-1:0] r_mask;
  logic [DRP_DATA_W-1:0] r_data;
  logic                  r_last;
  logic [DRP_ADDR_W-1:0] r_daddr;
  logic [DRP_DATA_W-1:0] r_di;
  logic [TMR_W-1:0]      r_tmr;
  logic [FLT_W-1:0]      r_flt;
  logic [LTM_W-1:0]      r_ltm;
  logic                  r_mmcm_rst;
  logic                  r_err;
  logic [1:0]            r_err_code;
  logic                  r_clk_ok;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_capture_rd;
  logic                  w_fail;
  logic [1:0]            w_fail_code;
  logic                  w_success;
  logic [TMR_W-1:0]      w_tmr_inc;
  logic [FLT_W-1:0]      w_flt_nxt;
  logic [LTM_W-1:0]      w_ltm_inc;

  // Saturating counter steps; the lock filter restarts whenever lock drops.
  assign w_tmr_inc = (r_tmr == '1) ? r_tmr : r_tmr + TMR_ONE;
  assign w_ltm_inc = (r_ltm == '1) ? r_ltm : r_ltm + LTM_ONE;
  assign w_flt_nxt = !r_lock_s2 ? '0 : ((r_flt == '1) ? r_flt : r_flt + FLT_ONE);

  // r_run keeps op_ready low while reset is asserted, so every output reads 0 in reset.
  assign w_ready  = r_run && ((r_state == S_IDLE) || (r_state == S_GET_OP));
  assign w_accept = w_ready && op_valid;

  // Next-state decode plus the single-cycle events that steer the datapath.
  always_comb begin
    w_state_nxt  = r_state;
    w_capture_rd = 1'b0;
    w_fail       = 1'b0;
    w_fail_code  = ERR_NONE;
    w_success    = 1'b0;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_RD_REQ;
      S_RD_REQ:  w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        if (drp_drdy) begin
          w_capture_rd = 1'b1;
          w_state_nxt  = S_WR_REQ;
        end else if (w_tmr_inc == TMR_LIMIT) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_DRDY;
          w_state_nxt = S_DONE;
        end
      end
      S_WR_REQ:  w_state_nxt = S_WR_WAIT;
      S_WR_WAIT: begin
        if (drp_drdy) begin
          w_state_nxt = r_last ? S_RELEASE : S_GET_OP;
        end else if (w_tmr_inc == TMR_LIMIT) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_DRDY;
          w_state_nxt = S_DONE;
        end
      end
      S_GET_OP:  if (w_accept) w_state_nxt = S_RD_REQ;
      S_RELEASE: w_state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        // Success is tested first so it wins a tie with the timeout.
        if (w_flt_nxt == FLT_LIMIT) begin
          w_success   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_ltm_inc == LTM_LIMIT) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_LOCK;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sysclk_200mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
    end
  end

  // Two-flop synchroniser for the asynchronous MMCM lock.
  always_ff @(posedge sysclk_200mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= mmcm_locked;
      r_lock_s2 <= r_lock_s1;
    end
  end

  // Op capture and DRP address/data; both hold their last value while den is low.
  always_ff @(posedge sysclk_200mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_mask  <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_daddr <= '0;
      r_di    <= '0;
    end else begin
      if (w_accept) begin
        r_mask  <= op_mask;
        r_data  <= op_data;
        r_last  <= op_last;
        r_daddr <= op_addr;
      end
      if (w_capture_rd) r_di <= (drp_do & r_mask) | (r_data & ~r_mask);
    end
  end

  // drdy timer (the den cycle counts as the first), lock filter and lock timer.
  always_ff @(posedge sysclk_200mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
      r_flt <= '0;
      r_ltm <= '0;
    end else begin
      case (r_state)
        S_RD_REQ, S_WR_REQ:   r_tmr <= TMR_ONE;
        S_RD_WAIT, S_WR_WAIT: r_tmr <= w_tmr_inc;
        default:              r_tmr <= '0;
      endcase
      if (r_state == S_WAIT_LOCK) begin
        r_flt <= w_flt_nxt;
        r_ltm <= w_ltm_inc;
      end else begin
        r_flt <= '0;
        r_ltm <= '0;
      end
    end
  end

  // MMCM reset and the sticky status flags.
  always_ff @(posedge sysclk_200mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_mmcm_rst <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_clk_ok   <= 1'b0;
    end else begin
      if (w_accept && (r_state == S_IDLE)) begin
        r_mmcm_rst <= 1'b1;
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
        r_clk_ok   <= 1'b0;
      end else if (w_fail) begin
        r_mmcm_rst <= 1'b0;
        r_err      <= 1'b1;
        r_err_code <= w_fail_code;
        r_clk_ok   <= 1'b0;
      end else if (w_success) begin
        r_clk_ok   <= 1'b1;
      end else if (w_state_nxt == S_RELEASE) begin
        r_mmcm_rst <= 1'b0;
      end else if ((r_state == S_IDLE) && !r_lock_s2) begin
        r_clk_ok   <= 1'b0;
      end
    end
  end

  assign op_ready  = w_ready;
  assign drp_den   = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
  assign drp_dwe   = (r_state == S_WR_REQ);
  assign drp_daddr = r_daddr;
  assign drp_di    = r_di;
  assign mmcm_rst  = r_mmcm_rst;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign clk_ok    = r_clk_ok;
  assign dbg_state = r_state;

endmodule

// File: doc/mmcm_drp_ctrl.md
Name: mmcm_drp_ctrl

Overview:
- Sequences run-time reconfiguration of the MMCM that generates the fabric clocks from the 200 MHz differential system clock.
- Accepts a stream of read-modify-write ops and holds the MMCM in reset while it applies them over the DRP port.
- Releases the MMCM reset after the last op and qualifies lock with a stability filter and a timeout.
- Runs on the buffered 200 MHz system clock, which does not depend on MMCM output.

Parameters:
- DRP_ADDR_W, 7: DRP address width.
- DRP_DATA_W, 16: DRP data width.
- DRDY_TIMEOUT, 64: max cycles from den to drdy.
- LOCK_FILTER, 16: consecutive synced-locked cycles required for lock.
- LOCK_TIMEOUT, 65535: max cycles in WAIT_LOCK.

Ports:
- sysclk_200mhz  in  1  sole clock.
- rst_n  in  1  async active-low reset.
- op_valid  in  1  op present.
- op_ready  out  1  op accepted when op_valid & op_ready.
- op_addr  in  DRP_ADDR_W  DRP register address.
- op_mask  in  DRP_DATA_W  1 = keep the read bit.
- op_data  in  DRP_DATA_W  new bits, used where mask = 0.
- op_last  in  1  last op of the sequence.
- drp_den  out  1  DRP enable, single-cycle pulse.
- drp_dwe  out  1  DRP write enable.
- drp_daddr  out  DRP_ADDR_W  DRP address.
- drp_di  out  DRP_DATA_W  DRP write data.
- drp_do  in  DRP_DATA_W  DRP read data.
- drp_drdy  in  1  DRP ready.
- mmcm_rst  out  1  MMCM reset, active high.
- mmcm_locked  in  1  MMCM locked, asynchronous.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at sequence end (success or error).
- err  out  1  sticky error flag.
- err_code  out  2  0 none, 1 drdy timeout, 2 lock timeout.
- clk_ok  out  1  filtered lock status.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- mmcm_locked: 2-flop synchronised before any use.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, GET_OP, RELEASE, WAIT_LOCK, DONE.
- op_ready: 1 only in IDLE and GET_OP.
- Op capture: op_addr/op_mask/op_data/op_last registered on accept.
- IDLE accept:
  - set mmcm_rst=1, clk_ok=0, err=0, err_code=0; go RD_REQ.
  - drp_den rises the cycle after accept.
- RD_REQ: den=1, dwe=0, daddr=addr for exactly 1 cycle; go RD_WAIT with timer cleared.
- RD_WAIT:
  - on drdy, wdata = (drp_do & mask) | (data & ~mask); go WR_REQ.
  - timer reaches DRDY_TIMEOUT with no drdy -> error 1.
- WR_REQ: den=1, dwe=1, daddr=addr, di=wdata for 1 cycle; go WR_WAIT.
- WR_WAIT:
  - drdy -> RELEASE if last, else GET_OP.
  - same timeout rule as RD_WAIT -> error 1.
- GET_OP: mmcm_rst stays 1; waits indefinitely; accept -> RD_REQ.
- drdy outside RD_WAIT/WR_WAIT: ignored.
- RELEASE: mmcm_rst=0; filter and lock timer cleared; go WAIT_LOCK next cycle.
- WAIT_LOCK:
  - filter count increments while synced locked=1 and resets to 0 when it is 0.
  - count == LOCK_FILTER -> DONE.
  - lock timer == LOCK_TIMEOUT -> error 2.
  - if both occur on the same cycle, success wins.
- DONE: done=1, clk_ok=1 for 1 cycle; go IDLE.
- Error: mmcm_rst=0, err=1, err_code set, done=1 for 1 cycle, clk_ok=0; go IDLE. Any remaining ops are not consumed.
- clk_ok in IDLE: clears when synced locked drops; not reasserted until the next successful sequence.
- drp_daddr/drp_di: hold last values when den=0.
- Reset mid-operation: immediate return to reset values (mmcm_rst=0). No DRP transaction is completed.
- Counters: saturate, never wrap.

Test Plan:
- Single op: addr=0x08, mask=0xF000, data=0x0145, read returns 0xA3C2 after 3 cycles -> write di=0xA145, then mmcm_rst falls, locked held for 16 cycles -> done pulse, clk_ok=1, err=0.
- Three ops with op_valid gaps of 5 cycles -> mmcm_rst held high continuously, 3 reads and 3 writes in order, released only after third write drdy.
- drdy never returned on the read -> exactly 64 cycles after den: err=1, err_code=1, done pulse, mmcm_rst=0, no write issued.
- Locked toggles every 10 cycles after release -> never passes filter, err_code=2 at cycle 65535; then locked stable -> no clk_ok until a new sequence.
- Assert rst_n low during WR_WAIT -> all outputs 0 on the next edge; new op after reset completes normally.
- Spurious drdy in IDLE and GET_OP -> no state change, no error.
